// File: rtl/uart_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_unit
//  Brief    : UART 8N1 transmitter, one WORD_BYTES-byte word per handshake,
//             least-significant byte first.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 4,
    localparam int DATA_WIDTH  = 8 * WORD_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [1:0]          c_BYTE_LAST = 2'(WORD_BYTES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]            r_state,    w_state_nxt;
    logic [c_BAUD_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]            r_bit_cnt,  w_bit_cnt_nxt;
    logic [1:0]            r_byte_cnt, w_byte_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
    logic                  r_tx,       w_tx_nxt;
    logic                  r_tx_ready, w_tx_ready_nxt;
    logic                  r_tx_busy,  w_tx_busy_nxt;
    logic                  r_tx_done,  w_tx_done_nxt;

    logic                  w_accept;
    logic                  w_bit_end;
    logic [7:0]            w_cur_byte;
    logic [2:0]            w_bit_inc;

    assign w_accept   = tx_valid & r_tx_ready;
    assign w_bit_end  = (r_baud_cnt == c_BAUD_LAST);
    assign w_cur_byte = r_shift[7:0];
    assign w_bit_inc  = r_bit_cnt + 3'd1;

    // State and every output are registered together; reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
            r_tx_done  <= w_tx_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_START;
            c_ST_START: if (w_bit_end) w_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_state_nxt = c_ST_STOP;
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = (r_byte_cnt < c_BYTE_LAST) ? c_ST_START : c_ST_IDLE;
                end
            end
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_baud_cnt_nxt = '0;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_tx_ready_nxt = r_tx_ready;
        w_tx_busy_nxt  = r_tx_busy;
        w_tx_done_nxt  = 1'b0;

        if (r_state != c_ST_IDLE) begin
            w_baud_cnt_nxt = w_bit_end ? '0 : (r_baud_cnt + c_BAUD_ONE);
        end

        unique case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt    = tx_data;
                    w_byte_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_tx_nxt       = 1'b0;
                    w_tx_ready_nxt = 1'b0;
                    w_tx_busy_nxt  = 1'b1;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = w_cur_byte[0];
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_tx_nxt = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = w_bit_inc;
                        w_tx_nxt      = w_cur_byte[w_bit_inc];
                    end
                end
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    if (r_byte_cnt < c_BYTE_LAST) begin
                        // Next byte starts immediately: no gap between bytes of a word.
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        w_shift_nxt    = r_shift >> 8;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_tx_nxt       = 1'b1;
                        w_tx_ready_nxt = 1'b1;
                        w_tx_busy_nxt  = 1'b0;
                        w_tx_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt = 1'b1;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;
    assign tx_done  = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_unit
//  Brief    : Directed self-checking bench for uart_tx_unit (4-clk bits, 4-byte
//             words) plus a default-parameter instance (868-clk bits, 1 byte).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_unit;

    localparam int CPB = 4;
    localparam int WB  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready, tx, tx_busy, tx_done;

    logic [7:0]  d_data;
    logic        d_valid;
    logic        d_ready, d_tx, d_busy, d_done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int low_cnt  = 0;

    always #5 clk = ~clk;

    uart_tx_unit #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx_unit #(.WORD_BYTES(1)) u_dut_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (d_data),
        .tx_valid (d_valid),
        .tx_ready (d_ready),
        .tx       (d_tx),
        .tx_busy  (d_busy),
        .tx_done  (d_done)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (!tx) low_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns positioned in the accept cycle.
    task automatic send_word(input logic [31:0] w);
        logic was_ready;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            was_ready = tx_ready;
            step(1);
            if (was_ready) begin
                tx_valid = 1'b0;
                return;
            end
        end
        tx_valid = 1'b0;
        check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Called in the accept cycle; samples bit centres, returns at accept + 10*WB*CPB.
    task automatic rx_word(output logic [31:0] w);
        logic [7:0] b8;
        logic       st, sp;
        w = '0;
        step(CPB / 2);
        for (int b = 0; b < WB; b++) begin
            st = tx;
            for (int i = 0; i < 8; i++) begin
                step(CPB);
                b8[i] = tx;
            end
            step(CPB);
            sp = tx;
            check_eq("framing", {30'd0, st, sp}, 32'd1);
            w[b*8 +: 8] = b8;
            if (b < WB - 1) step(CPB);
        end
        step(1);
        check_eq("done_early", {30'd0, tx_done, tx_ready}, 32'd0);
        step(1);
        check_eq("word_end", {28'd0, tx_done, tx_ready, tx_busy, tx}, 32'hD);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  bits;
        int          d0;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        d_valid  = 1'b0;
        d_data   = '0;
        w        = '0;
        bits     = '0;

        step(3);
        check_eq("rst_state", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'hC);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq("idle_state", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'hC);
        end

        // First word in flight while the next word is already offered.
        d0 = done_cnt;
        send_word(32'h12345678);
        tx_data  = 32'hDEADBEEF;
        tx_valid = 1'b1;
        rx_word(w);
        check_eq("word_12345678", w, 32'h12345678);
        step(1);
        check_eq("done_once", done_cnt - d0, 32'd1);
        check_eq("b2b_accept", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'h2);
        tx_valid = 1'b0;
        rx_word(w);
        check_eq("word_deadbeef", w, 32'hDEADBEEF);

        // Asynchronous abort in the second byte.
        step(1);
        send_word(32'hA5A5A5A5);
        step(49);
        check_eq("pre_abort_tx", {31'd0, tx}, 32'd0);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1 check_eq("async_abort", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'hC);
        step(3);
        rst_n = 1'b1;
        step(2);
        check_eq("abort_no_done", done_cnt - d0, 32'd0);
        check_eq("post_abort_idle", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'hC);
        send_word(32'h0000003C);
        rx_word(w);
        check_eq("word_3c", w, 32'h0000003C);

        // Extreme data patterns: count low cycles over the whole word.
        step(1);
        low_cnt = 0;
        send_word(32'hFFFFFFFF);
        rx_word(w);
        check_eq("word_ffffffff", w, 32'hFFFFFFFF);
        check_eq("low_cycles_ff", low_cnt, 32'd16);
        low_cnt = 0;
        send_word(32'h00000000);
        rx_word(w);
        check_eq("word_00000000", w, 32'h00000000);
        check_eq("low_cycles_00", low_cnt, 32'd144);

        // Default-parameter instance: 868-clk bits, single byte 0x55.
        d_data  = 8'h55;
        d_valid = 1'b1;
        step(1);
        d_valid = 1'b0;
        check_eq("dflt_accept", {30'd0, d_tx, d_ready}, 32'd0);
        step(867);
        check_eq("dflt_start_last", {31'd0, d_tx}, 32'd0);
        step(1);
        check_eq("dflt_bit0_first", {31'd0, d_tx}, 32'd1);
        step(867);
        check_eq("dflt_bit0_last", {31'd0, d_tx}, 32'd1);
        step(1);
        check_eq("dflt_bit1_first", {31'd0, d_tx}, 32'd0);
        step(434);
        for (int i = 2; i < 8; i++) begin
            step(868);
            bits[i] = d_tx;
        end
        check_eq("dflt_bits_7_2", {26'd0, bits[7:2]}, 32'h15);
        step(868);
        check_eq("dflt_stop", {31'd0, d_tx}, 32'd1);
        step(433);
        check_eq("dflt_done_early", {30'd0, d_done, d_ready}, 32'd0);
        step(1);
        check_eq("dflt_done", {28'd0, d_done, d_ready, d_busy, d_tx}, 32'hD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
